shift_rows_pipe: RTL and testbench

//  Streaming, parametrised AES/Rijndael ShiftRows unit for the SIMD vector datapath.
//  - Accepts one state vector per cycle over a valid/ready handshake.
//  - Applies forward ShiftRows, InvShiftRows or bypass, selected per transaction.
//  - Buffers results in a 2-entry output queue, so back-pressure does not cost throughput.
//  - Sits between the SubBytes and MixColumns stages of the vector cipher pipeline.

---
 rtl/aes_pkg.sv | 18 +
 rtl/shift_rows_perm.sv | 30 +++
 rtl/shift_rows_pipe.sv | 79 +++++++
 tb/tb_shift_rows_pipe.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types and helpers for the vector cipher ShiftRows stage.
package aes_pkg;

  typedef enum logic [1:0] {
    SR_FWD = 2'b00,
    SR_INV = 2'b01,
    SR_BYP = 2'b10,
    SR_ILL = 2'b11
  } shift_mode_t;

  localparam int FIFO_DEPTH = 2;

  // Rijndael with Nb=8 skips one extra position on rows 2 and up.
  function automatic int row_off(int r, int nb);
    return (r + ((nb == 8 && r >= 2) ? 1 : 0)) % nb;
  endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// Combinational ShiftRows / InvShiftRows / bypass byte permutation.
module shift_rows_perm
  import aes_pkg::*;
#(
  parameter int REG_SIZE = 32,
  parameter int VEC_SIZE = 4
) (
  input  shift_mode_t                         mode,
  input  logic [VEC_SIZE-1:0][REG_SIZE-1:0]   vect_in,
  output logic [VEC_SIZE-1:0][REG_SIZE-1:0]   vect_out
);

  localparam int NR = REG_SIZE / 8;

  // Source columns are elaboration-time constants, so each output byte is a 3:1 mux.
  for (genvar c = 0; c < VEC_SIZE; c++) begin : g_col
    for (genvar r = 0; r < NR; r++) begin : g_row
      localparam int OFF     = row_off(r, VEC_SIZE);
      localparam int SRC_FWD = (c + OFF) % VEC_SIZE;
      localparam int SRC_INV = (c - OFF + VEC_SIZE) % VEC_SIZE;
      localparam int HI      = REG_SIZE - 1 - 8 * r;

      assign vect_out[c][HI -: 8] =
        (mode == SR_FWD) ? vect_in[SRC_FWD][HI -: 8] :
        (mode == SR_INV) ? vect_in[SRC_INV][HI -: 8] :
                           vect_in[c][HI -: 8];
    end
  end

endmodule

// File: rtl/shift_rows_pipe.sv
// Streaming ShiftRows unit: permutes on entry, then buffers results in a 2-entry FIFO.
module shift_rows_pipe
  import aes_pkg::*;
#(
  parameter int REG_SIZE = 32,
  parameter int VEC_SIZE = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [1:0]                          in_mode,
  input  logic [VEC_SIZE-1:0][REG_SIZE-1:0]   in_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [VEC_SIZE-1:0][REG_SIZE-1:0]   out_data,
  output logic                                illegal_mode
);

  logic [VEC_SIZE-1:0][REG_SIZE-1:0] r_mem [FIFO_DEPTH];
  logic                              r_wrPtr;
  logic                              r_rdPtr;
  logic [1:0]                        r_count;
  logic                              r_inReady;
  logic                              r_illegal;

  shift_mode_t                       w_mode;
  logic [VEC_SIZE-1:0][REG_SIZE-1:0] w_perm;
  logic                              w_push;
  logic                              w_pop;
  logic [1:0]                        w_countNext;

  assign w_mode      = shift_mode_t'(in_mode);
  assign w_push      = in_valid && r_inReady;
  assign w_pop       = (r_count != 2'd0) && out_ready;
  assign w_countNext = r_count + {1'b0, w_push} - {1'b0, w_pop};

  shift_rows_perm #(
    .REG_SIZE (REG_SIZE),
    .VEC_SIZE (VEC_SIZE)
  ) u_perm (
    .mode     (w_mode),
    .vect_in  (in_data),
    .vect_out (w_perm)
  );

  // Storage is cleared too so out_data reads zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wrPtr   <= 1'b0;
      r_rdPtr   <= 1'b0;
      r_count   <= 2'd0;
      r_inReady <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wrPtr] <= w_perm;
        r_wrPtr        <= ~r_wrPtr;
      end
      if (w_pop) begin
        r_rdPtr <= ~r_rdPtr;
      end
      r_count   <= w_countNext;
      r_inReady <= (w_countNext < 2'(FIFO_DEPTH));
      if (w_push && (w_mode == SR_ILL)) begin
        r_illegal <= 1'b1;
      end
    end
  end

  assign in_ready     = r_inReady;
  assign out_valid    = (r_count != 2'd0);
  assign out_data     = r_mem[r_rdPtr];
  assign illegal_mode = r_illegal;

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Self-checking bench: Nb=4 and Nb=8 instances checked against a byte-matrix reference model.
module tb_shift_rows_pipe;

  typedef logic [7:0][31:0] vec8_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic            inValid4, inReady4, outValid4, outReady4, illegal4;
  logic [1:0]      inMode4;
  logic [3:0][31:0] inData4, outData4;

  logic            inValid8, inReady8, outValid8, outReady8, illegal8;
  logic [1:0]      inMode8;
  logic [7:0][31:0] inData8, outData8;

  int checks = 0;
  int errors = 0;

  vec8_t exp4[$];
  vec8_t exp8[$];
  bit    illModel4, illModel8;
  int    pops4 = 0;
  int    pops8 = 0;

  shift_rows_pipe #(.REG_SIZE(32), .VEC_SIZE(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(inValid4), .in_ready(inReady4), .in_mode(inMode4), .in_data(inData4),
    .out_valid(outValid4), .out_ready(outReady4), .out_data(outData4),
    .illegal_mode(illegal4)
  );

  shift_rows_pipe #(.REG_SIZE(32), .VEC_SIZE(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(inValid8), .in_ready(inReady8), .in_mode(inMode8), .in_data(inData8),
    .out_valid(outValid8), .out_ready(outReady8), .out_data(outData8),
    .illegal_mode(illegal8)
  );

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: view the state as a row/column byte matrix and rotate each row left by its offset.
  function automatic vec8_t refShift(input int nb, input logic [1:0] mode, input vec8_t d);
    logic [7:0] st [4][8];
    vec8_t res;
    res = '0;
    for (int c = 0; c < nb; c++)
      for (int r = 0; r < 4; r++)
        st[r][c] = d[c][31-8*r -: 8];
    for (int r = 0; r < 4; r++) begin
      int sh;
      sh = r;
      if (nb == 8 && r >= 2) sh = sh + 1;
      for (int c = 0; c < nb; c++) begin
        int src;
        case (mode)
          2'b00:   src = (c + sh) % nb;
          2'b01:   src = ((c - sh) % nb + nb) % nb;
          default: src = c;
        endcase
        res[c][31-8*r -: 8] = st[r][src];
      end
    end
    return res;
  endfunction

  function automatic vec8_t randVec();
    vec8_t v;
    for (int c = 0; c < 8; c++) v[c] = $urandom;
    return v;
  endfunction

  // Scoreboard: inputs are stable between posedge+1 and the next posedge, so the
  // negedge sees exactly what the coming edge will transfer.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp4.delete();
      exp8.delete();
      illModel4 = 1'b0;
      illModel8 = 1'b0;
    end else begin
      if (outValid4 && outReady4) begin
        if (exp4.size() == 0) checkOutput("spurious4", 256'(exp4.size() != 0), 256'd1);
        else begin
          checkOutput("data4", {128'b0, outData4}, exp4.pop_front());
          pops4++;
        end
      end
      if (outValid8 && outReady8) begin
        if (exp8.size() == 0) checkOutput("spurious8", 256'(exp8.size() != 0), 256'd1);
        else begin
          checkOutput("data8", outData8, exp8.pop_front());
          pops8++;
        end
      end
      checkOutput("illegal4", 256'(illegal4), 256'(illModel4));
      checkOutput("illegal8", 256'(illegal8), 256'(illModel8));
      if (inValid4 && inReady4) begin
        exp4.push_back(refShift(4, inMode4, {128'b0, inData4}));
        if (inMode4 == 2'b11) illModel4 = 1'b1;
      end
      if (inValid8 && inReady8) begin
        exp8.push_back(refShift(8, inMode8, inData8));
        if (inMode8 == 2'b11) illModel8 = 1'b1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic applyStimulus(input bit wide, input logic [1:0] mode, input vec8_t data);
    bit acc;
    acc = 1'b0;
    if (wide) begin
      inValid8 = 1'b1; inMode8 = mode; inData8 = data;
    end else begin
      inValid4 = 1'b1; inMode4 = mode; inData4 = data[3:0];
    end
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = wide ? inReady8 : inReady4;
      @(posedge clk);
      #1;
    end
    if (!acc) checkOutput("acceptTimeout", 256'(acc), 256'd1);
    if (wide) inValid8 = 1'b0;
    else      inValid4 = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec8_t tv1, fwd1, d8, v0, v1, v2, vr;
    int    p0;

    rst_n = 1'b0;
    inValid4 = 0; inMode4 = 0; inData4 = '0; outReady4 = 0;
    inValid8 = 0; inMode8 = 0; inData8 = '0; outReady8 = 0;

    tick(3);
    checkOutput("rstOutValid", 256'(outValid4), 256'd0);
    checkOutput("rstInReady", 256'(inReady4), 256'd0);
    checkOutput("rstIllegal", 256'(illegal4), 256'd0);
    checkOutput("rstOutData", {128'b0, outData4}, 256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("inReadyPreEdge", 256'(inReady4), 256'd0);
    @(posedge clk);
    #1;
    checkOutput("inReadyRise", 256'(inReady4), 256'd1);

    // Known-answer forward ShiftRows, one cycle latency.
    outReady4 = 1'b1;
    outReady8 = 1'b1;
    tv1  = {128'b0, 32'h7575d2d2, 32'h7676c0c0, 32'h7b7bc5c5, 32'h63637c7c};
    fwd1 = {128'b0, 32'h7563c5c0, 32'h76757cc5, 32'h7b76d27c, 32'h637bc0d2};
    applyStimulus(1'b0, 2'b00, tv1);
    checkOutput("latency1", 256'(outValid4), 256'd1);
    checkOutput("fwdNb4", {128'b0, outData4}, fwd1);

    applyStimulus(1'b0, 2'b01, fwd1);
    checkOutput("invNb4", {128'b0, outData4}, tv1);
    vr = randVec();
    applyStimulus(1'b0, 2'b10, vr);
    checkOutput("bypNb4", {128'b0, outData4}, {128'b0, vr[3:0]});

    // Nb=8 known answer: row r of column c holds byte {r,c}.
    for (int c = 0; c < 8; c++)
      for (int r = 0; r < 4; r++)
        d8[c][31-8*r -: 8] = 8'(r * 16 + c);
    applyStimulus(1'b1, 2'b00, d8);
    checkOutput("fwdNb8col0", 256'(outData8[0]), 256'h00112334);
    checkOutput("fwdNb8col7", 256'(outData8[7]), 256'h07102233);

    // Back-pressure: fill both entries, third vector must wait.
    tick(2);
    outReady4 = 1'b0;
    v0 = randVec(); v1 = randVec(); v2 = randVec();
    p0 = pops4;
    applyStimulus(1'b0, 2'b00, v0);
    applyStimulus(1'b0, 2'b01, v1);
    checkOutput("fullInReady", 256'(inReady4), 256'd0);
    inValid4 = 1'b1; inMode4 = 2'b10; inData4 = v2[3:0];
    tick(3);
    checkOutput("fullStillBlocked", 256'(inReady4), 256'd0);
    checkOutput("holdValid", 256'(outValid4), 256'd1);
    checkOutput("holdHead", {128'b0, outData4}, refShift(4, 2'b00, {128'b0, v0[3:0]}));
    outReady4 = 1'b1;
    applyStimulus(1'b0, 2'b10, v2);
    for (int i = 0; i < 20 && (exp4.size() != 0 || outValid4); i++) tick(1);
    checkOutput("drainCount4", 256'(pops4 - p0), 256'd3);
    checkOutput("drainEmpty4", 256'(outValid4), 256'd0);

    // Streaming at full rate.
    p0 = pops4;
    for (int i = 0; i < 16; i++) begin
      inValid4 = 1'b1;
      inMode4  = 2'($urandom_range(0, 2));
      inData4  = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      checkOutput("streamReady", 256'(inReady4), 256'd1);
      if (i > 0) checkOutput("streamValid", 256'(outValid4), 256'd1);
      @(posedge clk);
      #1;
    end
    inValid4 = 1'b0;
    tick(2);
    checkOutput("streamCount", 256'(pops4 - p0), 256'd16);

    // Illegal mode passes data through and latches the flag.
    vr = randVec();
    applyStimulus(1'b0, 2'b11, vr);
    checkOutput("illData", {128'b0, outData4}, {128'b0, vr[3:0]});
    checkOutput("illFlag", 256'(illegal4), 256'd1);
    tick(3);
    checkOutput("illHeld", 256'(illegal4), 256'd1);

    // Mid-stream reset with two vectors queued.
    outReady4 = 1'b0;
    applyStimulus(1'b0, 2'b00, randVec());
    applyStimulus(1'b0, 2'b01, randVec());
    checkOutput("queuedValid", 256'(outValid4), 256'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midRstValid", 256'(outValid4), 256'd0);
    checkOutput("midRstIllegal", 256'(illegal4), 256'd0);
    checkOutput("midRstInReady", 256'(inReady4), 256'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    checkOutput("relInReadyLow", 256'(inReady4), 256'd0);
    @(posedge clk);
    #1;
    checkOutput("relInReadyHigh", 256'(inReady4), 256'd1);
    checkOutput("relOutValid", 256'(outValid4), 256'd0);

    // Random traffic on both instances with random back-pressure.
    for (int i = 0; i < 400; i++) begin
      inValid4  = 1'($urandom_range(0, 1));
      inMode4   = 2'($urandom_range(0, 3));
      inData4   = {$urandom, $urandom, $urandom, $urandom};
      outReady4 = ($urandom_range(0, 3) != 0);
      inValid8  = 1'($urandom_range(0, 1));
      inMode8   = 2'($urandom_range(0, 3));
      inData8   = randVec();
      outReady8 = ($urandom_range(0, 3) != 0);
      tick(1);
    end
    inValid4 = 1'b0; inValid8 = 1'b0;
    outReady4 = 1'b1; outReady8 = 1'b1;
    tick(5);
    checkOutput("endEmpty4", 256'(exp4.size()), 256'd0);
    checkOutput("endEmpty8", 256'(exp8.size()), 256'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
